// File: rtl/cpu_types_pkg.sv
// Shared CPU types plus the fetch-stage additions (next-PC select, fetch FSM states).
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
    OP_BNE = 6'h05, OP_ADDIU = 6'h09, OP_HALT = 6'h3F
  } opcode_t;

  typedef enum logic [5:0] {
    FN_SLL = 6'h00, FN_JR = 6'h08, FN_JALR = 6'h09, FN_ADD = 6'h20, FN_ADDU = 6'h21
  } funct_t;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00, PC_BRANCH = 2'b01, PC_JUMP = 2'b10, PC_REG = 2'b11
  } pc_src_t;

  typedef enum logic [1:0] {FETCH, EXEC, HALTED} fetch_state_t;

  localparam word_t WORD_INC = 32'd4;

  // Word-aligned, sign-extended branch displacement from an I-type immediate.
  function automatic word_t br_offset(word_t ins);
    return {{14{ins[15]}}, ins[15:0], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection: sequential, branch, jump or register target.
module fetch_next_pc
  import cpu_types_pkg::*;
(
  input  word_t   pc,
  input  word_t   instr,
  input  pc_src_t pc_src,
  input  logic    bra,
  input  word_t   rs_data,
  output word_t   next_pc
);

  word_t seq_pc;
  assign seq_pc = pc + WORD_INC;

  always_comb begin
    next_pc = seq_pc;
    case (pc_src)
      PC_SEQ:    next_pc = seq_pc;
      PC_BRANCH: if (bra) next_pc = seq_pc + br_offset(instr);
      PC_JUMP:   next_pc = {seq_pc[31:28], instr[25:0], 2'b00};
      PC_REG:    next_pc = rs_data;
      default:   next_pc = seq_pc;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: PC, iREN/ihit handshake, instruction register.
// Define FETCH_PERF_CNT_EN to add saturating fetch/redirect counters.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC0 = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  output logic        iREN,
  output word_t       iaddr,
  input  logic        ihit,
  input  word_t       imemload,
  input  logic        PC_EN,
  input  logic [1:0]  PC_src,
  input  logic        bra,
  input  word_t       rs_data,
  input  logic        halt,
  output word_t       instr,
  output logic        instr_valid,
  output opcode_t     opcode,
  output funct_t      funct,
  output word_t       pc_plus4,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output word_t       fetch_count,
  output word_t       redirect_count
`endif
);

  fetch_state_t state;
  word_t        pc, next_pc;
  logic         accept, stop, retire;

  fetch_next_pc u_next_pc (
    .pc     (pc),
    .instr  (instr),
    .pc_src (pc_src_t'(PC_src)),
    .bra    (bra),
    .rs_data(rs_data),
    .next_pc(next_pc)
  );

  assign accept = (state == FETCH) && ihit;
  assign stop   = (state == EXEC) && instr_valid && halt;
  assign retire = (state == EXEC) && instr_valid && !halt && PC_EN;

  // Gated by nRST so no read is requested while reset is held.
  assign iREN     = nRST && (state == FETCH);
  assign iaddr    = pc;
  assign pc_plus4 = pc + WORD_INC;
  assign opcode   = opcode_t'(instr[31:26]);
  assign funct    = funct_t'(instr[5:0]);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= FETCH;
      pc          <= PC0;
      instr       <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        FETCH: if (accept) begin
          instr       <= imemload;
          instr_valid <= 1'b1;
          state       <= EXEC;
        end
        EXEC: if (stop) begin
          halted <= 1'b1;
          state  <= HALTED;
        end else if (retire) begin
          pc          <= next_pc;
          instr_valid <= 1'b0;
          state       <= FETCH;
        end
        HALTED: ;
        default: state <= FETCH;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_count    <= '0;
      redirect_count <= '0;
    end else begin
      if (accept && fetch_count != '1) fetch_count <= fetch_count + 32'd1;
      if (retire && next_pc != pc_plus4 && redirect_count != '1)
        redirect_count <= redirect_count + 32'd1;
    end
  end
`endif

  // The controller must only retire once decode holds a valid instruction.
  a_late_pc_en: assert property (@(posedge CLK) disable iff (!nRST) !(PC_EN && state == FETCH));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a transaction-level model of the fetch rules.
module tb_fetch_unit;

  localparam logic [31:0] PC0 = 32'h0000_0040;

  logic        CLK = 1'b0, nRST;
  logic        iREN, ihit, PC_EN, bra, halt, instr_valid, halted;
  logic [31:0] iaddr, imemload, rs_data, instr, pc_plus4;
  logic [1:0]  PC_src;
  logic [5:0]  opcode, funct;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count, redirect_count;
`endif

  fetch_unit #(.PC0(PC0)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .ihit(ihit),
    .imemload(imemload), .PC_EN(PC_EN), .PC_src(PC_src), .bra(bra),
    .rs_data(rs_data), .halt(halt), .instr(instr), .instr_valid(instr_valid),
    .opcode(opcode), .funct(funct), .pc_plus4(pc_plus4), .halted(halted)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fetch_count), .redirect_count(redirect_count)
`endif
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_fail = 0;
  bit started = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: "holding an instruction or not", plus PC, halted flag and counters.
  logic [31:0] m_pc, m_instr, m_fc, m_rc;
  logic        m_valid, m_halted;

  function automatic logic [31:0] ref_next(logic [31:0] pc, logic [31:0] ins,
                                            logic [1:0] src, logic b, logic [31:0] rs);
    int off;
    off = int'($signed(ins[15:0])) * 4;
    case (src)
      2'd0:    return pc + 32'd4;
      2'd1:    return b ? pc + 32'd4 + off : pc + 32'd4;
      2'd2:    return ((pc + 32'd4) & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
      default: return rs;
    endcase
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_pc <= PC0; m_instr <= '0; m_valid <= 1'b0; m_halted <= 1'b0;
      m_fc <= '0; m_rc <= '0;
    end else if (!m_halted) begin
      if (!m_valid) begin
        if (ihit) begin
          m_instr <= imemload;
          m_valid <= 1'b1;
          if (m_fc != 32'hFFFF_FFFF) m_fc <= m_fc + 1;
        end
      end else if (halt) begin
        m_halted <= 1'b1;
      end else if (PC_EN) begin
        m_pc    <= ref_next(m_pc, m_instr, PC_src, bra, rs_data);
        m_valid <= 1'b0;
        if (ref_next(m_pc, m_instr, PC_src, bra, rs_data) != m_pc + 32'd4 &&
            m_rc != 32'hFFFF_FFFF) m_rc <= m_rc + 1;
      end
    end
  end

  always @(negedge CLK) begin
    if (started) begin
      if (!nRST) begin
        check("iren_in_reset", 32'(iREN), 32'd0);
        check("iaddr_in_reset", iaddr, PC0);
      end else begin
        check("iaddr", iaddr, m_pc);
        check("iren", 32'(iREN), 32'(!m_halted && !m_valid));
        check("instr_valid", 32'(instr_valid), 32'(m_valid));
        check("halted", 32'(halted), 32'(m_halted));
        if (m_valid) begin
          check("instr", instr, m_instr);
          check("opcode", 32'(opcode), m_instr >> 26);
          check("funct", 32'(funct), m_instr & 32'h3F);
          check("pc_plus4", pc_plus4, m_pc + 32'd4);
        end
`ifdef FETCH_PERF_CNT_EN
        check("fetch_count", fetch_count, m_fc);
        check("redirect_count", redirect_count, m_rc);
`endif
      end
    end
  end

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic idle_inputs();
    ihit = 1'b0; PC_EN = 1'b0; halt = 1'b0; bra = 1'b0;
    PC_src = 2'd0; rs_data = '0; imemload = '0;
  endtask

  task automatic do_fetch(logic [31:0] w);
    ihit = 1'b1; imemload = w;
    step();
    ihit = 1'b0; imemload = $urandom;
  endtask

  task automatic do_retire(logic [1:0] src, logic b, logic [31:0] rs);
    PC_EN = 1'b1; PC_src = src; bra = b; rs_data = rs;
    step();
    PC_EN = 1'b0; bra = 1'b0; PC_src = 2'd0;
  endtask

  task automatic jump_to(logic [31:0] a);
    do_fetch(32'h0000_0008);
    do_retire(2'd3, 1'b0, a);
  endtask

  logic [31:0] ops [6] = '{32'h2400_0000, 32'h1000_0000, 32'h0800_0000,
                            32'h0C00_0000, 32'h1400_0000, 32'h0000_0000};

  initial begin
    nRST = 1'b0;
    idle_inputs();
    started = 1'b1;
    repeat (3) step();
    check("reset_iren_low", 32'(iREN), 32'd0);
    nRST = 1'b1;
    repeat (5) step();
    check("idle_iaddr", iaddr, 32'h40);
    check("idle_iren", 32'(iREN), 32'd1);
    check("idle_valid", 32'(instr_valid), 32'd0);

    do_fetch(32'h2402_0005);
    check("addiu_valid", 32'(instr_valid), 32'd1);
    check("addiu_opcode", 32'(opcode), 32'h09);
    do_retire(2'd0, 1'b0, '0);
    check("seq_iaddr", iaddr, 32'h44);
    check("seq_iren", 32'(iREN), 32'd1);
    do_fetch(32'h1000_FFFE);
    do_retire(2'd1, 1'b1, '0);
    check("perf_branch_iaddr", iaddr, 32'h40);
    do_fetch(32'h2402_0005);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetch_literal", fetch_count, 32'd3);
    check("perf_redirect_literal", redirect_count, 32'd1);
`endif
    do_retire(2'd0, 1'b0, '0);

    jump_to(32'h100);
    do_fetch(32'h1000_FFFE);
    do_retire(2'd1, 1'b1, '0);
    check("branch_taken", iaddr, 32'h0FC);
    jump_to(32'h100);
    do_fetch(32'h1000_FFFE);
    do_retire(2'd1, 1'b0, '0);
    check("branch_not_taken", iaddr, 32'h104);
    jump_to(32'h0040_0010);
    do_fetch(32'h0800_0020);
    do_retire(2'd2, 1'b0, '0);
    check("jump", iaddr, 32'h80);
    do_fetch(32'h0000_0008);
    do_retire(2'd3, 1'b0, 32'h1234);
    check("jr", iaddr, 32'h1234);
    jump_to(32'hFFFF_FFFC);
    do_fetch(32'h0);
    do_retire(2'd0, 1'b0, '0);
    check("wrap", iaddr, 32'h0);

    do_fetch(32'hFC00_0000);
    halt = 1'b1; PC_EN = 1'b1;
    step();
    halt = 1'b0; PC_EN = 1'b0; ihit = 1'b1; imemload = 32'hDEAD_BEEF;
    for (int i = 0; i < 20; i++) begin
      check("halt_pc_frozen", iaddr, 32'h0);
      check("halt_flag", 32'(halted), 32'd1);
      check("halt_iren", 32'(iREN), 32'd0);
      step();
    end
    ihit = 1'b0;
    #2 nRST = 1'b0;
    #1 check("async_reset_pc", iaddr, PC0);
    #1 nRST = 1'b1;
    step();

    for (int c = 0; c < 4000; c++) begin
      ihit     = ($urandom_range(0, 2) != 0);
      imemload = ops[$urandom_range(0, 5)] | ($urandom & 32'h03FF_FFFF);
      PC_EN    = m_valid && !m_halted && ($urandom_range(0, 2) == 0);
      halt     = ($urandom_range(0, 150) == 0);
      PC_src   = 2'($urandom_range(0, 3));
      bra      = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 3))
        0:       rs_data = $urandom;
        1:       rs_data = 32'hFFFF_FFFC;
        default: rs_data = $urandom & ~32'd3;
      endcase
      if (m_halted && $urandom_range(0, 10) == 0) begin
        PC_EN = 1'b0; halt = 1'b0;
        nRST = 1'b0;
        #2 nRST = 1'b1;
      end
      step();
    end

    idle_inputs();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the MIPS CPU; sits directly upstream of the control unit.
- Owns the PC register and issues instruction-memory reads with an iREN/ihit handshake.
- Holds the fetched word in an instruction register and presents opcode/funct to decode.
- Computes the next PC from the control unit's PC_src, branch and jump information once the core asserts PC_EN.

Parameters:
- PC0, 32'h00000000, PC value loaded on reset.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- iREN  output  1  instruction read request.
- iaddr  output  32  instruction address; always equal to PC.
- ihit  input  1  memory has valid data on imemload this cycle.
- imemload  input  32  fetched instruction word.
- PC_EN  input  1  current instruction retired; advance PC.
- PC_src  input  2  next-PC select: 00 PC+4, 01 branch, 10 jump, 11 register.
- bra  input  1  branch condition true; used only when PC_src=01.
- rs_data  input  32  register target for jr/jalr.
- halt  input  1  halt decoded for current instruction.
- instr  output  32  instruction register.
- instr_valid  output  1  instr holds a fetched, unretired instruction.
- opcode  output  6  instr[31:26], as opcode_t.
- funct  output  6  instr[5:0], as funct_t.
- pc_plus4  output  32  PC+4, consumed by the jal/jalr link write.
- halted  output  1  fetch permanently stopped.

Behaviour:
- Reset is asynchronous on nRST low.
  - PC=PC0, instr=0, instr_valid=0, state=FETCH, halted=0.
  - iREN is 0 while nRST is low.
- States:
  - FETCH: iREN=1. On ihit, instr<=imemload, instr_valid<=1, go to EXEC.
  - EXEC: iREN=0, instr held stable.
    - On PC_EN: PC<=next_pc, instr_valid<=0, go to FETCH.
  - HALTED: iREN=0, halted=1, PC frozen. Exit only by reset.
- halt is sampled only in EXEC with instr_valid=1.
  - halt=1 moves to HALTED; PC is not updated.
  - halt has priority over a simultaneous PC_EN.
- Fetch latency: ihit in cycle N gives instr_valid=1 in cycle N+1.
  - Minimum 2 cycles per instruction: one fetch cycle plus one execute cycle.
- PC_EN while in FETCH is ignored. A late PC_EN is a controller bug; an assertion flags it.
- ihit while in EXEC or HALTED is ignored. instr is not overwritten.
- next_pc arithmetic is 32-bit modulo; wrap 0xFFFFFFFC -> 0x00000000 is legal.
  - 00: PC+4.
  - 01: PC+4+(signext(instr[15:0])<<2) if bra, else PC+4.
  - 10: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - 11: rs_data passed unmodified. The low two bits are not masked.
- opcode, funct and pc_plus4 are combinational from instr and PC. They are valid whenever instr_valid=1.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, the block adds two outputs:
  - fetch_count[31:0]: increments on every ihit accepted in FETCH.
  - redirect_count[31:0]: increments on every PC_EN with next_pc != PC+4.
  - Both counters saturate at 32'hFFFFFFFF and reset to 0.
  - Neither counter increments in HALTED.
- When not defined, the block has no counter ports or logic, and the port list is exactly as above.

Decomposition:
- Add to cpu_types_pkg:
  - pc_src_t enum: PC_SEQ=2'b00, PC_BRANCH=2'b01, PC_JUMP=2'b10, PC_REG=2'b11.
  - fetch_state_t enum: FETCH, EXEC, HALTED.
  - WORD_INC constant = 32'd4.
- Reuse word_t, opcode_t and funct_t from cpu_types_pkg.
- One combinational sub-module, fetch_next_pc: inputs PC, instr, PC_src, bra, rs_data; output next_pc. Tested standalone.

Test Plan:
- Reset with PC0=0x00000040, ihit held 0 -> iaddr=0x40, iREN=1, instr_valid=0 indefinitely.
- Sequential fetch: ihit=1 with imemload=0x24020005 -> next cycle instr_valid=1, opcode=0x09. PC_EN with PC_src=00 -> iaddr=0x44, iREN=1.
- Branch at PC=0x100, imm16=0xFFFE:
  - bra=1, PC_src=01 -> PC=0x0FC.
  - Repeat with bra=0 -> PC=0x104.
- Jump:
  - PC=0x00400010, instr=0x08000020, PC_src=10 -> PC=0x00000080.
  - jr with rs_data=0x1234 -> PC=0x1234.
- Halt priority: halt=1 and PC_EN=1 together in EXEC -> halted=1, iREN=0, PC unchanged for 20 cycles. Then nRST pulse mid-cycle -> PC=PC0 immediately.
- Wrap-around and perf counters:
  - PC=0xFFFFFFFC with PC_src=00 -> PC=0x0.
  - With FETCH_PERF_CNT_EN defined, 3 fetches including 1 taken branch -> fetch_count=3, redirect_count=1.
